// File: rtl/posit_accum_ctrl_8.sv
// posit_accum_ctrl_8
//
// Streaming reduction controller that sits upstream of posit_adder_8. It accepts a packet of
// posit<8,4> terms, folds them serially into one running sum through the external adder (one add
// outstanding at a time) and emits one sum per packet.
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   reset_i        synchronous reset, active high
//   in_valid_i     input term valid
//   in_ready_o     term accepted this cycle when in_valid_i is also high
//   in_data_i      posit term
//   in_last_i      term closes its packet
//   add_in1_o      adder operand 1 (running sum)
//   add_in2_o      adder operand 2 (new term)
//   add_start_o    one-cycle adder launch pulse
//   add_result_i   adder sum
//   add_inf_i      adder NaR flag
//   add_zero_i     adder zero flag (informational, not used)
//   add_done_i     adder result valid, single-cycle pulse
//   add_err_o      watchdog fired, sticky until reset (POSIT_ACC_WATCHDOG_EN only)
//   out_valid_o    packet sum valid, held until out_ready_i
//   out_ready_i    downstream accepts the sum
//   out_data_o     packet sum (NaR if any NaR was seen)
//   out_inf_o      sum is NaR
//   out_count_o    number of terms in the packet, saturating
//
// Optional feature: define POSIT_ACC_WATCHDOG_EN to add the add_done watchdog and add_err_o.
module posit_accum_ctrl_8 #(
    parameter int unsigned N           = 8,
    parameter int unsigned ADD_LATENCY = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N-1:0]     in_data_i,
    input  logic             in_last_i,
    output logic [N-1:0]     add_in1_o,
    output logic [N-1:0]     add_in2_o,
    output logic             add_start_o,
    input  logic [N-1:0]     add_result_i,
    input  logic             add_inf_i,
    input  logic             add_zero_i,
    input  logic             add_done_i,
`ifdef POSIT_ACC_WATCHDOG_EN
    output logic             add_err_o,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [N-1:0]     out_data_o,
    output logic             out_inf_o,
    output logic [CNT_W-1:0] out_count_o
);

    localparam logic [N-1:0] PositNaR = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StFetch, StWait, StOut} state_e;

    state_e             state_q;
    logic               in_ready_q;
    logic [N-1:0]       acc_q;
    logic               inf_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_q;
    logic [N-1:0]       add_in1_q;
    logic [N-1:0]       add_in2_q;
    logic               add_start_q;
    logic               out_valid_q;
    logic [N-1:0]       out_data_q;
    logic               out_inf_q;
    logic [CNT_W-1:0]   out_count_q;

    // Result of the outstanding add as seen this cycle (real or watchdog-forced).
    logic               done_evt;
    logic [N-1:0]       done_acc;
    logic               done_inf;
    logic               in_xfer;
    logic [CNT_W-1:0]   cnt_inc;

    // The zero flag carries no information we need: a zero sum is already 8'h00.
    logic unused_add_zero;
    assign unused_add_zero = add_zero_i;

`ifdef POSIT_ACC_WATCHDOG_EN
    // Counter is cleared on launch and reaches WdLimit in the last cycle add_done may still arrive.
    localparam int unsigned WdLimit = ADD_LATENCY + 1;
    localparam int unsigned WdW     = $clog2(WdLimit + 1);

    logic [WdW-1:0] wd_q;
    logic           add_err_q;
    logic           wd_fire;

    assign wd_fire   = (state_q == StWait) && !add_done_i && (wd_q == WdW'(WdLimit));
    assign add_err_o = add_err_q;
`endif

    assign in_xfer = in_valid_i && in_ready_q;
    // Term count saturates at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        done_evt = add_done_i;
        done_acc = add_result_i;
        done_inf = inf_q | add_inf_i;
`ifdef POSIT_ACC_WATCHDOG_EN
        if (wd_fire) begin
            done_evt = 1'b1;
            done_acc = PositNaR;
            done_inf = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b0;
            acc_q       <= '0;
            inf_q       <= 1'b0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            add_in1_q   <= '0;
            add_in2_q   <= '0;
            add_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_inf_q   <= 1'b0;
            out_count_q <= '0;
`ifdef POSIT_ACC_WATCHDOG_EN
            wd_q        <= '0;
            add_err_q   <= 1'b0;
`endif
        end else begin
            add_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    in_ready_q <= 1'b1;
                    if (in_xfer) begin
                        acc_q <= in_data_i;
                        inf_q <= (in_data_i == PositNaR);
                        cnt_q <= CNT_W'(1);
                        if (in_last_i) begin
                            // Single-term packet: no add, straight to output.
                            state_q     <= StOut;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= in_data_i;
                            out_inf_q   <= (in_data_i == PositNaR);
                            out_count_q <= CNT_W'(1);
                        end else begin
                            state_q <= StFetch;
                        end
                    end
                end
                StFetch: begin
                    if (in_xfer) begin
                        add_in1_q   <= acc_q;
                        add_in2_q   <= in_data_i;
                        add_start_q <= 1'b1;
                        last_q      <= in_last_i;
                        cnt_q       <= cnt_inc;
                        in_ready_q  <= 1'b0;
                        state_q     <= StWait;
`ifdef POSIT_ACC_WATCHDOG_EN
                        wd_q        <= '0;
`endif
                    end
                end
                StWait: begin
`ifdef POSIT_ACC_WATCHDOG_EN
                    wd_q <= wd_q + WdW'(1);
                    if (wd_fire) begin
                        add_err_q <= 1'b1;
                    end
`endif
                    if (done_evt) begin
                        acc_q <= done_acc;
                        inf_q <= done_inf;
                        if (last_q) begin
                            state_q     <= StOut;
                            out_valid_q <= 1'b1;
                            out_data_q  <= done_inf ? PositNaR : done_acc;
                            out_inf_q   <= done_inf;
                            out_count_q <= cnt_q;
                        end else begin
                            state_q    <= StFetch;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                StOut: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign add_in1_o   = add_in1_q;
    assign add_in2_o   = add_in2_q;
    assign add_start_o = add_start_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_inf_o   = out_inf_q;
    assign out_count_o = out_count_q;

endmodule
